// File: rtl/result_bcd_converter.sv
// Signed result to sign + magnitude BCD, sequential double-dabble one bit per clock.
// Rising edge of ready starts a conversion; a rise while busy is queued one deep.
module result_bcd_converter #(
  parameter int WORD_LENGTH = 9,
  parameter int DIGITS      = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  input  logic [2*WORD_LENGTH-1:0] Result,
  output logic                     busy,
  output logic                     done,
  output logic                     sign,
  output logic [4*DIGITS-1:0]      bcd
);

  localparam int RW = 2 * WORD_LENGTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(RW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(RW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state_q;
  logic          ready_q;
  logic          pending_q;
  logic          sign_r_q;
  logic          done_q;
  logic          sign_q;
  logic [RW-1:0] mag_q;
  logic [BW-1:0] scratch_q;
  logic [BW-1:0] bcd_q;
  logic [CW-1:0] cnt_q;

  logic          req;
  logic [RW-1:0] neg_mag;
  logic [BW-1:0] adj;
  logic [BW-1:0] scratch_d;
  logic [RW-1:0] mag_d;

  assign req     = ready & ~ready_q;
  // Magnitude is unsigned, so the most-negative input maps to 2^(RW-1) correctly.
  assign neg_mag = ~Result + RW'(1);

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    {scratch_d, mag_d} = {adj, mag_q} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      pending_q <= 1'b0;
      sign_r_q  <= 1'b0;
      done_q    <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      ready_q <= ready;
      done_q  <= 1'b0;
      if (req && state_q != IDLE) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (req || pending_q) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // A negative value is never zero, so this also rules out negative zero.
          sign_r_q  <= Result[RW-1] & (|Result);
          mag_q     <= Result[RW-1] ? neg_mag : Result;
          scratch_q <= '0;
          cnt_q     <= '0;
          pending_q <= req;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_d;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= scratch_q;
          sign_q  <= sign_r_q;
          done_q  <= 1'b1;
          state_q <= (pending_q || req) ? LOAD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign sign = sign_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter (WORD_LENGTH=9, DIGITS=6).
module tb_result_bcd_converter;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [17:0] Result;
  logic        busy;
  logic        done;
  logic        sign;
  logic [23:0] bcd;

  int vectors;
  int fails;

  result_bcd_converter #(.WORD_LENGTH(9), .DIGITS(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .ready  (ready),
    .Result (Result),
    .busy   (busy),
    .done   (done),
    .sign   (sign),
    .bcd    (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts sampled cycles until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
  endtask

  // Rise on ready, expect done 21 samples after the rise is set up; ready left high.
  task automatic convert(input logic [17:0] val, input logic exp_sign,
                         input logic [23:0] exp_bcd, input string tag);
    int n;
    @(negedge clk);
    ready  = 1'b0;
    Result = val;
    @(negedge clk);
    ready = 1'b1;
    wait_done(n);
    check({tag, "_latency"}, n, 21);
    check({tag, "_sign"}, {31'd0, sign}, {31'd0, exp_sign});
    check({tag, "_bcd"}, {8'd0, bcd}, {8'd0, exp_bcd});
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  function automatic logic [23:0] ref_bcd(input logic [17:0] r);
    int m;
    logic [23:0] res;
    m = r[17] ? 262144 - int'(r) : int'(r);
    res = '0;
    for (int i = 0; i < 6; i++) begin
      res[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return res;
  endfunction

  initial begin
    int n;
    int extra;
    logic [17:0] rv;
    vectors = 0;
    fails   = 0;
    reset   = 1'b1;
    ready   = 1'b0;
    Result  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sign", {31'd0, sign}, 32'd0);
    check("rst_bcd", {8'd0, bcd}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    convert(18'd65025, 1'b0, 24'h065025, "pos65025");
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("held_ready_no_retrigger", extra, 0);
    check("held_ready_idle", {31'd0, busy}, 32'd0);

    convert(-18'd65280, 1'b1, 24'h065280, "neg65280");
    convert(18'h20000, 1'b1, 24'h131072, "most_negative");
    convert(18'd0, 1'b0, 24'h000000, "zero");
    convert(18'd1, 1'b0, 24'h000001, "one");
    convert(18'h3FFFF, 1'b1, 24'h000001, "minus_one");
    convert(18'h1FFFF, 1'b0, 24'h131071, "most_positive");
    convert(18'd99999, 1'b0, 24'h099999, "pos99999");

    // Second rise during SHIFT queues a conversion of the new Result.
    @(negedge clk);
    ready  = 1'b0;
    Result = 18'd12345;
    @(negedge clk);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    check("pend_busy_in_shift", {31'd0, busy}, 32'd1);
    ready  = 1'b0;
    Result = 18'd7;
    @(negedge clk);
    ready = 1'b1;
    wait_done(n);
    check("pend_first_seen", {31'd0, done}, 32'd1);
    check("pend_first_bcd", {8'd0, bcd}, 32'h012345);
    wait_done(n);
    check("pend_gap", n, 20);
    check("pend_second_bcd", {8'd0, bcd}, 32'h000007);
    check("pend_second_sign", {31'd0, sign}, 32'd0);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("pend_merged_only_once", extra, 0);

    // Reset mid-SHIFT after a negative result is on the outputs.
    convert(-18'd5, 1'b1, 24'h000005, "neg5");
    @(negedge clk);
    ready  = 1'b0;
    Result = 18'd999;
    @(negedge clk);
    ready = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    ready = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_sign", {31'd0, sign}, 32'd0);
    check("midrst_bcd", {8'd0, bcd}, 32'd0);
    ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midrst_pending_cleared", extra, 0);

    for (int i = 0; i < 8; i++) begin
      rv = 18'($urandom_range(0, 262143));
      convert(rv, rv[17], ref_bcd(rv), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
